pin_entry_ctrl: RTL and testbench

Keypad front-end of the multibanco machine, sitting directly upstream of `MB`. It collects and checks the 4-digit PIN against the card's reference PIN, then takes the operation code and value. It presents `EN`/`PIN`/`COD`/`VAL` to `MB` through a hold-until-acknowledge handshake. It also handles card abort, inactivity timeout, and retention of the card after repeated wrong PINs.

---
 rtl/atm_pkg.sv | 34 +++
 rtl/pin_shift_reg.sv | 36 +++
 rtl/pin_entry_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state encoding, key codes and op codes for the ATM keypad front-end
package atm_pkg;

  // Encoding is exported on STATE for the display driver, so the order is fixed
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PIN_ENTRY = 3'd1,
    ST_PIN_CHECK = 3'd2,
    ST_OP_SELECT = 3'd3,
    ST_VAL_ENTRY = 3'd4,
    ST_ISSUE     = 3'd5,
    ST_EJECT     = 3'd6,
    ST_LOCKED    = 3'd7
  } state_t;

  localparam logic [3:0] KEY_CANCEL = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_ENTER  = 4'hC;

  localparam logic [3:0] OP_WITHDRAW = 4'd1;
  localparam logic [3:0] OP_DEPOSIT  = 4'd2;
  localparam logic [3:0] OP_BALANCE  = 4'd3;
  localparam logic [3:0] OP_TRANSFER = 4'd4;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // States in which the user is expected to type and the inactivity timer runs
  function automatic logic is_timed(input state_t s);
    return (s == ST_PIN_ENTRY) || (s == ST_OP_SELECT) || (s == ST_VAL_ENTRY);
  endfunction

endpackage

// File: rtl/pin_shift_reg.sv
// rtl/pin_shift_reg.sv - BCD PIN shift buffer with saturating digit count and reference compare
module pin_shift_reg #(
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [3:0]            i_digit,
  input  logic [4*DIGITS-1:0]   i_ref,
  output logic                  o_full,
  output logic                  o_match
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [4*DIGITS-1:0] r_buf;
  logic [CW-1:0]       r_count;
  logic                w_full;

  assign w_full  = (r_count == CW'(DIGITS));
  assign o_full  = w_full;
  assign o_match = (r_buf == i_ref);

  // Digits past the last position are dropped rather than shifted, so the first DIGITS keys stand
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (i_shift && !w_full) begin
      r_buf   <= (r_buf << 4) | (4*DIGITS)'(i_digit);
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/pin_entry_ctrl.sv
// rtl/pin_entry_ctrl.sv - keypad PIN/op/value collection FSM feeding MB; PIN_LOCKOUT_EN enables wrong-PIN lockout
module pin_entry_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CARD_IN,
  input  logic [4*PIN_DIGITS-1:0] REF_PIN,
  input  logic                    KEY_VALID,
  input  logic [3:0]              KEY,
  input  logic                    TXN_ACK,
  output logic                    EN,
  output logic                    PIN,
  output logic [3:0]              COD,
  output logic [3:0]              VAL,
  output logic [2:0]              STATE,
  output logic [1:0]              TRIES_LEFT,
  output logic                    CARD_EJECT,
  output logic                    CARD_RETAIN
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t        r_state, w_next;
  logic          r_en, r_pin, r_eject;
  logic [3:0]    r_cod, r_val;
  logic [TW-1:0] r_tmo;
  logic          w_pin_n;
  logic [3:0]    w_cod_n, w_val_n;
  logic          w_sr_clear, w_sr_shift, w_sr_full, w_sr_match;
  logic          w_timeout, w_digit;

  assign w_digit   = is_digit(KEY);
  assign w_timeout = is_timed(r_state) && (r_tmo == TW'(TIMEOUT_CYC - 1));

  pin_shift_reg #(
    .DIGITS (PIN_DIGITS)
  ) u_pin_sr (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clear (w_sr_clear),
    .i_shift (w_sr_shift),
    .i_digit (KEY),
    .i_ref   (REF_PIN),
    .o_full  (w_sr_full),
    .o_match (w_sr_match)
  );

`ifdef PIN_LOCKOUT_EN
  logic [1:0] r_tries, w_tries_n;
  logic       r_retain;
  assign TRIES_LEFT  = r_tries;
  assign CARD_RETAIN = r_retain;
`else
  assign TRIES_LEFT  = 2'(MAX_TRIES);
  assign CARD_RETAIN = 1'b0;
`endif

  assign EN         = r_en;
  assign PIN        = r_pin;
  assign COD        = r_cod;
  assign VAL        = r_val;
  assign STATE      = r_state;
  assign CARD_EJECT = r_eject;

  // Next state and next register values; card removal beats timeout beats ack beats keys
  always_comb begin
    w_next     = r_state;
    w_pin_n    = r_pin;
    w_cod_n    = r_cod;
    w_val_n    = r_val;
    w_sr_clear = 1'b0;
    w_sr_shift = 1'b0;
`ifdef PIN_LOCKOUT_EN
    w_tries_n  = r_tries;
`endif
    if (r_state != ST_IDLE && !CARD_IN) begin
      w_next     = ST_IDLE;
      w_pin_n    = 1'b0;
      w_cod_n    = 4'd0;
      w_val_n    = 4'd0;
      w_sr_clear = 1'b1;
`ifdef PIN_LOCKOUT_EN
      w_tries_n  = 2'(MAX_TRIES);
`endif
    end else if (w_timeout) begin
      w_next = ST_EJECT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CARD_IN) begin
            w_next     = ST_PIN_ENTRY;
            w_sr_clear = 1'b1;
`ifdef PIN_LOCKOUT_EN
            w_tries_n  = 2'(MAX_TRIES);
`endif
          end
        end
        ST_PIN_ENTRY: begin
          if (KEY_VALID) begin
            if (w_digit)                            w_sr_shift = 1'b1;
            else if (KEY == KEY_CLEAR)              w_sr_clear = 1'b1;
            else if (KEY == KEY_ENTER && w_sr_full) w_next     = ST_PIN_CHECK;
            else if (KEY == KEY_CANCEL)             w_next     = ST_EJECT;
          end
        end
        ST_PIN_CHECK: begin
          // The buffer is wiped on every exit so the typed PIN never lingers
          w_sr_clear = 1'b1;
          if (w_sr_match) begin
            w_pin_n = 1'b1;
            w_next  = ST_OP_SELECT;
          end else begin
`ifdef PIN_LOCKOUT_EN
            w_tries_n = r_tries - 2'd1;
            w_next    = (r_tries <= 2'd1) ? ST_LOCKED : ST_PIN_ENTRY;
`else
            w_next    = ST_PIN_ENTRY;
`endif
          end
        end
        ST_OP_SELECT: begin
          if (KEY_VALID) begin
            if (KEY == OP_WITHDRAW || KEY == OP_DEPOSIT || KEY == OP_TRANSFER) begin
              w_cod_n = KEY;
              w_next  = ST_VAL_ENTRY;
            end else if (KEY == OP_BALANCE) begin
              w_cod_n = OP_BALANCE;
              w_val_n = 4'd0;
              w_next  = ST_ISSUE;
            end else if (KEY == KEY_CANCEL) begin
              w_next  = ST_EJECT;
            end
          end
        end
        ST_VAL_ENTRY: begin
          if (KEY_VALID) begin
            if (w_digit)                                w_val_n = KEY;
            else if (KEY == KEY_CLEAR)                  w_val_n = 4'd0;
            else if (KEY == KEY_ENTER && r_val != 4'd0) w_next  = ST_ISSUE;
            else if (KEY == KEY_CANCEL)                 w_next  = ST_EJECT;
          end
        end
        ST_ISSUE: begin
          if (TXN_ACK) begin
            w_cod_n = 4'd0;
            w_val_n = 4'd0;
            w_next  = ST_OP_SELECT;
          end
        end
        ST_EJECT, ST_LOCKED: begin
          w_next = r_state;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; EN/EJECT/RETAIN are decoded from the next state so they align with STATE
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_pin   <= 1'b0;
      r_cod   <= 4'd0;
      r_val   <= 4'd0;
      r_eject <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en    <= (w_next == ST_ISSUE);
      r_pin   <= w_pin_n;
      r_cod   <= w_cod_n;
      r_val   <= w_val_n;
      r_eject <= (w_next == ST_EJECT);
    end
  end

  // Inactivity counter restarts on any key and on every state change, and idles outside typing states
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmo <= '0;
    end else if (KEY_VALID || (w_next != r_state) || !is_timed(r_state)) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

`ifdef PIN_LOCKOUT_EN
  // Remaining attempts and the retain flag for the lockout path
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tries  <= 2'(MAX_TRIES);
      r_retain <= 1'b0;
    end else begin
      r_tries  <= w_tries_n;
      r_retain <= (w_next == ST_LOCKED);
    end
  end
`endif

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb/tb_pin_entry_ctrl.sv - scoreboard bench for pin_entry_ctrl
module tb_pin_entry_ctrl;

  localparam int T_CYC = 16;
  localparam logic [31:0] S_IDLE = 0, S_PENT = 1, S_PCHK = 2, S_OPS = 3,
                          S_VALE = 4, S_ISS = 5, S_EJ = 6, S_LCK = 7;
  localparam logic [3:0] K_CAN = 4'hA, K_CLR = 4'hB, K_ENT = 4'hC;

  logic        CLK = 1'b0, RST = 1'b1, CARD_IN = 1'b0, KEY_VALID = 1'b0, TXN_ACK = 1'b0;
  logic [15:0] REF_PIN = 16'h1234;
  logic [3:0]  KEY = 4'd0;
  logic        EN, PIN, CARD_EJECT, CARD_RETAIN;
  logic [3:0]  COD, VAL;
  logic [2:0]  STATE;
  logic [1:0]  TRIES_LEFT;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  logic       en_d = 1'b0;
  logic [7:0] sb_exp;

  pin_entry_ctrl #(.PIN_DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYC(T_CYC)) dut (
    .CLK(CLK), .RST(RST), .CARD_IN(CARD_IN), .REF_PIN(REF_PIN),
    .KEY_VALID(KEY_VALID), .KEY(KEY), .TXN_ACK(TXN_ACK),
    .EN(EN), .PIN(PIN), .COD(COD), .VAL(VAL), .STATE(STATE),
    .TRIES_LEFT(TRIES_LEFT), .CARD_EJECT(CARD_EJECT), .CARD_RETAIN(CARD_RETAIN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] k);
    KEY = k;
    KEY_VALID = 1'b1;
    @(negedge CLK);
    KEY_VALID = 1'b0;
    KEY = 4'd0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) press(p[i*4 +: 4]);
    press(K_ENT);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, STATE, S_IDLE);
    check({tag, "_en"}, EN, 0);
    check({tag, "_pin"}, PIN, 0);
    check({tag, "_cod"}, COD, 0);
    check({tag, "_val"}, VAL, 0);
    check({tag, "_tries"}, TRIES_LEFT, 3);
    check({tag, "_eject"}, CARD_EJECT, 0);
    check({tag, "_retain"}, CARD_RETAIN, 0);
  endtask

  // Every rising EN is a transaction to MB; compare it with the oldest expected one
  always @(negedge CLK) begin
    if (!RST && EN && !en_d) begin
      check("sb_pending", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        sb_exp = sb_q.pop_front();
        check("txn_cod", COD, sb_exp[7:4]);
        check("txn_val", VAL, sb_exp[3:0]);
      end
    end
    en_d <= EN;
  end

  initial begin
    tick(3);
    check_idle("rst");
    RST = 1'b0;
    tick(1);
    check("idle_hold", STATE, S_IDLE);

    // Card in, short PIN then ENTER is ignored, 5th digit dropped
    CARD_IN = 1'b1;
    tick(1);
    check("card_in_state", STATE, S_PENT);
    press(4'd1); press(4'd2); press(K_ENT);
    check("short_enter", STATE, S_PENT);
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(K_ENT);
    check("pin_check_state", STATE, S_PCHK);
    tick(1);
    check("pin_ok_state", STATE, S_OPS);
    check("pin_ok", PIN, 1);

    // Ignored keys in OP_SELECT
    press(4'd0); press(K_ENT);
    check("ops_ignore", STATE, S_OPS);

    // Withdraw 5, ack held two cycles
    press(4'd1);
    check("val_entry_state", STATE, S_VALE);
    check("val_entry_cod", COD, 1);
    press(4'd5);
    sb_q.push_back({4'd1, 4'd5});
    press(K_ENT);
    check("issue_en", EN, 1);
    check("issue_state", STATE, S_ISS);
    press(4'd7);
    tick(2);
    check("issue_hold_en", EN, 1);
    check("issue_hold_cod", COD, 1);
    check("issue_hold_val", VAL, 5);
    TXN_ACK = 1'b1;
    tick(2);
    TXN_ACK = 1'b0;
    check("ack_en", EN, 0);
    check("ack_state", STATE, S_OPS);
    check("ack_cod", COD, 0);
    check("ack_val", VAL, 0);
    check("ack_pin", PIN, 1);

    // Deposit: ENTER with zero value ignored, last digit wins
    press(4'd2);
    press(K_ENT);
    check("zero_enter", STATE, S_VALE);
    check("zero_enter_en", EN, 0);
    press(4'd7); press(4'd9);
    check("last_digit", VAL, 9);
    sb_q.push_back({4'd2, 4'd9});
    press(K_ENT);
    check("dep_en", EN, 1);
    TXN_ACK = 1'b1;
    tick(1);
    TXN_ACK = 1'b0;
    check("dep_ack_en", EN, 0);

    // Balance goes straight to ISSUE; then abort coincident with ack
    sb_q.push_back({4'd3, 4'd0});
    press(4'd3);
    check("bal_en", EN, 1);
    check("bal_cod", COD, 3);
    check("bal_val", VAL, 0);
    CARD_IN = 1'b0;
    TXN_ACK = 1'b1;
    tick(1);
    TXN_ACK = 1'b0;
    check_idle("abort");

    // Inactivity timeout in OP_SELECT
    CARD_IN = 1'b1;
    tick(1);
    enter_pin(16'h1234);
    tick(1);
    check("tmo_ops", STATE, S_OPS);
    tick(T_CYC - 1);
    check("tmo_edge", STATE, S_OPS);
    check("tmo_edge_ej", CARD_EJECT, 0);
    tick(1);
    check("tmo_state", STATE, S_EJ);
    check("tmo_eject", CARD_EJECT, 1);
    CARD_IN = 1'b0;
    tick(1);
    check_idle("tmo_out");

    // Wrong PIN three times
    CARD_IN = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      enter_pin(16'h9999);
      tick(1);
`ifdef PIN_LOCKOUT_EN
      check("bad_tries", TRIES_LEFT, 2 - i);
      check("bad_state", STATE, (i == 2) ? S_LCK : S_PENT);
`else
      check("bad_tries", TRIES_LEFT, 3);
      check("bad_state", STATE, S_PENT);
`endif
      check("bad_pin", PIN, 0);
    end
`ifdef PIN_LOCKOUT_EN
    check("locked_retain", CARD_RETAIN, 1);
`else
    check("no_retain", CARD_RETAIN, 0);
    press(K_CAN);
    check("cancel_state", STATE, S_EJ);
    check("cancel_eject", CARD_EJECT, 1);
`endif
    CARD_IN = 1'b0;
    tick(1);
    check_idle("bad_out");

    tick(2);
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
